// File: rtl/clock_enable_divider.sv
// ---------------------------------------------------------------------------
// clock_enable_divider
//   Fully synchronous programmable divider. One counter on clk produces a
//   one-cycle clock-enable pulse (tick) and an observation square wave
//   (clk_out). The divisor can be reprogrammed at run time; a new value only
//   takes effect on a period boundary, so neither output ever shows a runt.
//   clk_out is meant for pins/LEDs; downstream logic should use clk + tick.
//
// Parameters
//   WIDTH        counter / divisor width
//   DEFAULT_DIV  divisor active after reset (0 halts the divider)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           count enable; low freezes count and clk_out
//   sync_clr     synchronous restart of the current period
//   div_value    requested divisor N
//   div_load     one-cycle strobe capturing div_value
//   tick         one-cycle pulse once per N enabled cycles
//   clk_out      square wave, N>>1 cycles low then the rest high
//   count        current counter value
//   load_pending captured divisor waiting for the next period boundary
// ---------------------------------------------------------------------------
module clock_enable_divider #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned DEFAULT_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    output logic             tick,
    output logic             clk_out,
    output logic [WIDTH-1:0] count,
    output logic             load_pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] active_div_q, active_div_d;
    logic [WIDTH-1:0] pending_div_q, pending_div_d;
    logic             load_pending_q, load_pending_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;

    logic             halted;
    logic             last_cnt;
    logic             imm_load;
    logic             wrap;
    logic [WIDTH-1:0] boundary_div;

    always_comb begin
        halted   = (active_div_q == '0);
        // >= rather than == keeps the counter from running away should
        // count ever sit above the active divisor.
        last_cnt = !halted && (count_q >= active_div_q - ONE);
        // With the counter frozen, halted, or at N=1 there is no period in
        // flight worth protecting, so a load takes effect straight away.
        imm_load = div_load && (!en || (active_div_q <= ONE));
        wrap     = en && last_cnt;

        // Divisor that governs the period starting at a boundary: a load on
        // this very edge beats a previously captured one.
        if (div_load)            boundary_div = div_value;
        else if (load_pending_q) boundary_div = pending_div_q;
        else                     boundary_div = active_div_q;
    end

    always_comb begin
        count_d        = count_q;
        active_div_d   = active_div_q;
        pending_div_d  = pending_div_q;
        load_pending_d = load_pending_q;
        tick_d         = 1'b0;
        clk_out_d      = clk_out_q;

        if (sync_clr) begin
            count_d        = '0;
            clk_out_d      = 1'b0;
            active_div_d   = boundary_div;
            load_pending_d = 1'b0;
        end else if (imm_load) begin
            count_d        = '0;
            clk_out_d      = 1'b0;
            active_div_d   = div_value;
            load_pending_d = 1'b0;
        end else if (en) begin
            if (halted) begin
                count_d   = '0;
                clk_out_d = 1'b0;
            end else begin
                if (wrap) begin
                    count_d        = '0;
                    tick_d         = 1'b1;
                    active_div_d   = boundary_div;
                    load_pending_d = 1'b0;
                end else begin
                    count_d = count_q + ONE;
                    if (div_load) begin
                        pending_div_d  = div_value;
                        load_pending_d = 1'b1;
                    end
                end
                // Phase is judged against the divisor that owns the next
                // count, so a boundary switch never produces a short level.
                clk_out_d = (active_div_d != '0) && (count_d >= (active_div_d >> 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q        <= '0;
            active_div_q   <= DEF_DIV;
            pending_div_q  <= '0;
            load_pending_q <= 1'b0;
            tick_q         <= 1'b0;
            clk_out_q      <= 1'b0;
        end else begin
            count_q        <= count_d;
            active_div_q   <= active_div_d;
            pending_div_q  <= pending_div_d;
            load_pending_q <= load_pending_d;
            tick_q         <= tick_d;
            clk_out_q      <= clk_out_d;
        end
    end

    assign tick         = tick_q;
    assign clk_out      = clk_out_q;
    assign count        = count_q;
    assign load_pending = load_pending_q;

endmodule
